// File: rtl/repeat_count_sequencer.sv
// Repeat-each-value counter controller: steps cnt 0..limit, holding each value rpt_cfg valid cycles.
// Optional RPT_AUTO_RESTART_EN: DONE restarts the run directly instead of returning to IDLE.
module repeat_count_sequencer #(
  parameter int CNT_W      = 2,
  parameter int RPT_W      = 3,
  parameter int DEF_REPEAT = 5,
  parameter int DEF_LIMIT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [RPT_W-1:0] cfg_repeat,
  input  logic [CNT_W-1:0] cfg_limit,
  output logic             cfg_err,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  localparam logic [RPT_W-1:0] REP_ONE = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_DEF = RPT_W'(DEF_REPEAT);
  localparam logic [CNT_W-1:0] LIM_DEF = CNT_W'(DEF_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RPT_W-1:0] rep_q, rep_d;
  logic [RPT_W-1:0] rpt_cfg_q, rpt_cfg_d;
  logic [CNT_W-1:0] lim_cfg_q, lim_cfg_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_accept;
  logic             rep_last;
  logic             last_elem;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    rpt_cfg_d  = rpt_cfg_q;
    lim_cfg_d  = lim_cfg_q;
    cfg_err_d  = 1'b0;
    cfg_accept = cfg_valid && (state_q == S_IDLE);
    rep_last   = (rep_q == rpt_cfg_q);
    last_elem  = rep_last && (cnt_q == lim_cfg_q);

    if (cfg_accept) begin
      lim_cfg_d = cfg_limit;
      if (cfg_repeat == '0) begin
        rpt_cfg_d = REP_ONE;
        cfg_err_d = 1'b1;
      end else begin
        rpt_cfg_d = cfg_repeat;
      end
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        rep_d = REP_ONE;
        if (start && !abort) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rep_d   = REP_ONE;
        end else if (last_elem) begin
          // Completion wins over pause: the final element has already been emitted.
          state_d = S_DONE;
        end else begin
          // The element shown this cycle is consumed even when pausing, so HOLD
          // parks on the next element and resume neither drops nor repeats one.
          if (rep_last) begin
            rep_d = REP_ONE;
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            rep_d = rep_q + REP_ONE;
          end
          if (pause) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rep_d   = REP_ONE;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        cnt_d = '0;
        rep_d = REP_ONE;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
`ifdef RPT_AUTO_RESTART_EN
          state_d = S_RUN;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        rep_d   = REP_ONE;
      end
    endcase

    // Status outputs are registered copies of what the next state implies.
    cnt_valid_d = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    cfg_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rep_q       <= REP_ONE;
      rpt_cfg_q   <= RPT_DEF;
      lim_cfg_q   <= LIM_DEF;
      cnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      rpt_cfg_q   <= rpt_cfg_d;
      lim_cfg_q   <= lim_cfg_d;
      cnt_valid_q <= cnt_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign cnt       = cnt_q;
  assign cnt_valid = cnt_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_repeat_count_sequencer.sv
// Bench for repeat_count_sequencer: element-index reference model checked every cycle,
// directed runs with literal expectations, then randomized traffic.
module tb_repeat_count_sequencer;
  localparam int CNT_W = 2;
  localparam int RPT_W = 3;
`ifdef RPT_AUTO_RESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [RPT_W-1:0] cfg_repeat = '0;
  logic [CNT_W-1:0] cfg_limit = '0;
  logic             cfg_err;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] cnt;
  logic             cnt_valid;
  logic             busy;
  logic             done;

  repeat_count_sequencer #(.CNT_W(CNT_W), .RPT_W(RPT_W), .DEF_REPEAT(5), .DEF_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_repeat(cfg_repeat), .cfg_limit(cfg_limit), .cfg_err(cfg_err),
    .start(start), .pause(pause), .abort(abort), .cnt(cnt),
    .cnt_valid(cnt_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a run is a stream of (lim+1)*rpt elements indexed by m_idx;
  // element i carries value i/rpt. Modes: 0 idle, 1 emitting, 2 stalled, 3 finished.
  int m_mode, m_idx, m_rpt, m_lim, m_err;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_idx = 0; m_rpt = 5; m_lim = 3; m_err = 0;
    end else begin
      m_err = 0;
      case (m_mode)
        0: begin
          if (cfg_valid) begin
            m_lim = int'(cfg_limit);
            m_rpt = (cfg_repeat == 0) ? 1 : int'(cfg_repeat);
            m_err = (cfg_repeat == 0) ? 1 : 0;
          end
          if (start && !abort) begin m_mode = 1; m_idx = 0; end
        end
        1: begin
          if (abort) m_mode = 0;
          else begin
            m_idx++;
            if (m_idx == (m_lim + 1) * m_rpt) m_mode = 3;
            else if (pause) m_mode = 2;
          end
        end
        2: begin
          if (abort) m_mode = 0;
          else if (!pause) m_mode = 1;
        end
        default: begin
          if (!abort && AUTO) begin m_mode = 1; m_idx = 0; end
          else m_mode = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int exp_cnt;
      exp_cnt = (m_mode == 1 || m_mode == 2) ? m_idx / m_rpt : (m_mode == 3 ? m_lim : 0);
      check("cnt", int'(cnt), exp_cnt);
      check("cnt_valid", int'(cnt_valid), int'(m_mode == 1));
      check("busy", int'(busy), int'(m_mode != 0));
      check("done", int'(done), int'(m_mode == 3));
      check("cfg_ready", int'(cfg_ready), int'(m_mode == 0));
      check("cfg_err", int'(cfg_err), m_err);
    end
  end

  int got[$];
  int done_cyc, idle_cyc, err_cyc;

  // Issues start (optionally with config) and observes the run cycle by cycle;
  // cycle n is the n-th cycle after start was sampled.
  task automatic run_seq(input bit do_cfg, input int rpt, input int lim,
                         input int pause_at, input int pause_len, input int abort_at,
                         input int rst_at, input int poke_at);
    @(negedge clk);
    cfg_valid = do_cfg; cfg_repeat = RPT_W'(rpt); cfg_limit = CNT_W'(lim); start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    got.delete(); done_cyc = 0; idle_cyc = 0; err_cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      if (cnt_valid && done_cyc == 0) got.push_back(int'(cnt));
      if (done && done_cyc == 0) done_cyc = n;
      if (cfg_err && err_cyc == 0) err_cyc = n;
      if (!busy) begin idle_cyc = n; break; end
      pause = (pause_at > 0) && (n >= pause_at) && (n < pause_at + pause_len);
      abort = (n == abort_at) || (done && AUTO);
      rst   = (n == rst_at);
      start = (n == poke_at); cfg_valid = (n == poke_at);
      cfg_repeat = RPT_W'(1); cfg_limit = CNT_W'(0);
      @(negedge clk);
    end
    pause = 0; abort = 0; rst = 0; start = 0; cfg_valid = 0;
    if (idle_cyc == 0) check("run_timeout", 0, 1);
  endtask

  task automatic check_seq(input string name, input int rpt, input int lim);
    check({name, "_len"}, got.size(), (lim + 1) * rpt);
    foreach (got[i]) check({name, "_val"}, got[i], i / rpt);
  endtask

  initial begin
    int lit[4];
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_cnt", int'(cnt), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Default 5/3 run
    run_seq(0, 0, 0, 0, 0, 0, 0, 0);
    check_seq("base", 5, 3);
    check("base_done_cyc", done_cyc, 21);
    check("base_idle_cyc", idle_cyc, 22);

    // Pause while cnt=1, rep=3 (cycle 8) for three cycles
    run_seq(0, 0, 0, 8, 3, 0, 0, 0);
    check_seq("pause", 5, 3);
    check("pause_done_cyc", done_cyc, 24);

    // start/cfg during run ignored; next run still uses 5/3
    run_seq(0, 0, 0, 0, 0, 0, 0, 5);
    check_seq("poke", 5, 3);
    check("poke_done_cyc", done_cyc, 21);
    run_seq(0, 0, 0, 0, 0, 0, 0, 0);
    check("poke_after_done_cyc", done_cyc, 21);

    // Abort at first cnt=2 cycle
    run_seq(0, 0, 0, 0, 0, 11, 0, 0);
    check("abort_len", got.size(), 11);
    check("abort_done", done_cyc, 0);
    check("abort_idle_cyc", idle_cyc, 12);

    // New config with same-cycle start, then repeat without config
    lit = '{0, 0, 1, 1};
    for (int r = 0; r < 2; r++) begin
      run_seq(r == 0, 2, 1, 0, 0, 0, 0, 0);
      check("cfg21_len", got.size(), 4);
      foreach (got[i]) if (i < 4) check("cfg21_val", got[i], lit[i]);
      check("cfg21_done_cyc", done_cyc, 5);
    end

    // Zero repeat stored as one, with error pulse
    run_seq(1, 0, 2, 0, 0, 0, 0, 0);
    check("err_cyc", err_cyc, 1);
    check_seq("rpt0", 1, 2);
    check("rpt0_done_cyc", done_cyc, 4);

    // Reset mid-run at cnt=2 restores defaults
    run_seq(1, 2, 3, 0, 0, 0, 5, 0);
    check("rst_len", got.size(), 5);
    check("rst_done", done_cyc, 0);
    check("rst_idle_cyc", idle_cyc, 6);
    run_seq(0, 0, 0, 0, 0, 0, 0, 0);
    check_seq("post_rst", 5, 3);
    check("post_rst_done_cyc", done_cyc, 21);

`ifdef RPT_AUTO_RESTART_EN
    // 1/0 config: valid, done, then valid with cnt 0 again
    @(negedge clk);
    cfg_valid = 1; cfg_repeat = 3'd1; cfg_limit = 2'd0; start = 1;
    @(negedge clk);
    cfg_valid = 0; start = 0;
    check("auto_c1_valid", int'(cnt_valid), 1);
    @(negedge clk);
    check("auto_c2_done", int'(done), 1);
    @(negedge clk);
    check("auto_c3_valid", int'(cnt_valid), 1);
    check("auto_c3_cnt", int'(cnt), 0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("auto_abort_busy", int'(busy), 0);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start      = ($urandom_range(0, 3) == 0);
      pause      = ($urandom_range(0, 4) == 0);
      abort      = ($urandom_range(0, 40) == 0);
      cfg_valid  = ($urandom_range(0, 5) == 0);
      cfg_repeat = RPT_W'($urandom_range(0, 7));
      cfg_limit  = CNT_W'($urandom_range(0, 3));
      rst        = ($urandom_range(0, 250) == 0);
    end
    @(negedge clk);
    start = 0; pause = 0; abort = 0; cfg_valid = 0; rst = 0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/repeat_count_sequencer.md
Name: repeat_count_sequencer

Overview:
- Run-time programmable controller for the "repeat-each-value" special counter: steps a count 0..limit, holding each value for a programmable number of cycles.
- Sits between control logic and downstream consumers of the repeated count. Provides config handshake, start/abort/pause sequencing, busy/done status and a qualified count stream.

Parameters:
- CNT_W, 2, width of count value and limit.
- RPT_W, 3, width of repeat count.
- DEF_REPEAT, 5, repeat count loaded at reset (1..2^RPT_W-1).
- DEF_LIMIT, 3, final count value loaded at reset.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accepted when cfg_valid && cfg_ready.
- cfg_repeat  input  RPT_W  cycles each value is held.
- cfg_limit  input  CNT_W  last count value of a run.
- cfg_err  output  1  one-cycle pulse: cfg_repeat==0 was accepted.
- start  input  1  begin run (sampled only in IDLE).
- pause  input  1  level; stalls sequence while high.
- abort  input  1  terminate run, return to IDLE.
- cnt  output  CNT_W  current count value.
- cnt_valid  output  1  cnt is a live sequence element this cycle.
- busy  output  1  high in RUN, HOLD, DONE.
- done  output  1  one-cycle pulse at run completion.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst). All outputs registered.
- Reset: state=IDLE, cnt=0, rep=1, cnt_valid=0, busy=0, done=0, cfg_err=0, cfg_ready=1, rpt_cfg=DEF_REPEAT, lim_cfg=DEF_LIMIT. rst mid-run discards run and config at next edge.
- States: IDLE, RUN, HOLD, DONE. Internal rep counter (RPT_W bits) runs 1..rpt_cfg.
- cfg_ready=1 only in IDLE. On accept: lim_cfg<=cfg_limit; rpt_cfg<=cfg_repeat, but cfg_repeat==0 stores 1 and pulses cfg_err next cycle. cfg_valid outside IDLE is ignored; no state change.
- IDLE->RUN on start. Same-cycle cfg accept + start: run uses new config. Entry: cnt=0, rep=1, cnt_valid=1 the cycle after start sampled.
- RUN, pause=0: rep<rpt_cfg -> rep++. rep==rpt_cfg -> rep<=1, cnt++. rep==rpt_cfg && cnt==lim_cfg -> DONE, cnt_valid<=0.
- RUN, pause=1 -> HOLD. HOLD: cnt/rep frozen, cnt_valid=0. pause low -> RUN, resumes exactly where stalled; no element dropped or repeated.
- Run length with no pause: (lim_cfg+1)*rpt_cfg valid cycles. Each value appears exactly rpt_cfg consecutive valid cycles.
- Count never wraps inside a run: lim_cfg=2^CNT_W-1 ends on the max value.
- DONE: lasts one cycle; done=1, busy=1, cnt holds final value. Next -> IDLE, cnt<=0.
- abort in RUN/HOLD/DONE: IDLE next edge, cnt=0, cnt_valid=0, no done pulse. abort has priority over pause; rst over all.
- start outside IDLE ignored. start && abort in IDLE: abort wins, stay IDLE.

Optional Feature:
- Macro RPT_AUTO_RESTART_EN.
- Defined: DONE -> RUN directly, with cnt=0, rep=1, cnt_valid=1, using current config. done still pulses each run. Only abort or rst returns to IDLE, so config changes require abort. Gap between runs is exactly one cycle (the DONE cycle).
- Undefined: DONE -> IDLE as above.

Test Plan:
- Defaults after rst, pulse start -> cnt_valid 20 cycles: 0x5,1x5,2x5,3x5; done pulse on cycle 21 after start; busy low on cycle 22; cnt=0.
- cfg_repeat=2, cfg_limit=1 with start same cycle -> 0,0,1,1 then done; second run without cfg repeats it.
- Defaults, pause high for 3 cycles while cnt=1, rep=3 -> 3 cycles cnt_valid=0 with cnt frozen; resume yields two more 1s, then 2s; done 3 cycles later than baseline.
- cfg_repeat=0, cfg_limit=2 -> cfg_err pulse; run emits 0,1,2 once each, then done.
- abort at cnt=2, and separately rst at cnt=2 -> IDLE next edge, cnt=0, no done. After rst, config is back to defaults (5/3).
- start and cfg_valid during RUN -> ignored; sequence and config unchanged. With RPT_AUTO_RESTART_EN: the cycle after done, cnt=0 and cnt_valid=1, and runs repeat until abort.
